// File: rtl/lottery_pkg.sv
// ============================================================================
// Module      : lottery_pkg
// Description : Shared types and sizes for the lottery round controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lottery_pkg;
    localparam int MAX_ENTRIES = 32;
    localparam int ID_W        = 5;
    localparam int CNT_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_DRAW   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;
endpackage

`default_nettype wire

// File: rtl/lottery_round_ctrl_if.sv
// ============================================================================
// Module      : lottery_round_ctrl_if
// Description : Requester, lottery and result signals of the round controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lottery_round_ctrl_if #(
    parameter int NUM_REQ = 4
);
    import lottery_pkg::*;

    localparam int PORT_W = $clog2(NUM_REQ);

    logic                 start;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_bit;
    logic [NUM_REQ-1:0]   ack;
    logic                 lot_write;
    logic                 lot_luckybit;
    logic                 lot_stop;
    logic                 lot_clear;
    logic                 lot_full;
    logic [ID_W-1:0]      lot_winner;
    logic                 busy;
    logic                 round_open;
    logic [CNT_W-1:0]     entry_count;
    logic                 result_valid;
    logic [ID_W-1:0]      result_id;
    logic [PORT_W-1:0]    result_port;
    logic                 result_empty;
    logic                 result_ack;

    modport master (
        input  start, req, req_bit, lot_full, lot_winner, result_ack,
        output ack, lot_write, lot_luckybit, lot_stop, lot_clear,
               busy, round_open, entry_count,
               result_valid, result_id, result_port, result_empty
    );

    modport slave (
        output start, req, req_bit, lot_full, lot_winner, result_ack,
        input  ack, lot_write, lot_luckybit, lot_stop, lot_clear,
               busy, round_open, entry_count,
               result_valid, result_id, result_port, result_empty
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot grant; pointer moves one past the winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    int               w_cand;

    // Scan starting at the pointer so the most recently served requester is last.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(w_cand);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant
        assign grant[g] = w_found && (w_idx == IDX_W'(g));
    end

    assign grant_idx = w_idx;
    assign grant_any = w_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/lottery_round_ctrl.sv
// ============================================================================
// Module      : lottery_round_ctrl
// Description : Runs one lottery round: clear, collect entries, draw, report.
//               LOTTERY_OWNER_TRACK_EN adds a per-entry owner table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lottery_round_ctrl
    import lottery_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ROUND_TIMEOUT = 1000,
    parameter int DRAW_WAIT     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    lottery_round_ctrl_if.master bus
);
    localparam int PORT_W = $clog2(NUM_REQ);
    localparam int TMR_W  = 16;
    localparam int DRW_W  = 4;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_entry_count;
    logic [TMR_W-1:0]    r_timer;
    logic [DRW_W-1:0]    r_draw_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_lot_write;
    logic                r_lot_luckybit;
    logic                r_lot_stop;
    logic                r_lot_clear;
    logic                r_busy;
    logic                r_round_open;
    logic                r_result_valid;
    logic [ID_W-1:0]     r_result_id;
    logic                r_result_empty;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PORT_W-1:0]   w_grant_idx;
    logic                w_grant_any;
    logic                w_grant_en;
    logic                w_do_grant;
    logic                w_exit;
    logic                w_last_draw;
    logic                w_round_empty;
    logic                w_round_start;
    logic                w_result_load;

    assign w_exit        = bus.lot_full
                         || (r_entry_count == CNT_W'(MAX_ENTRIES))
                         || (r_timer >= TMR_W'(ROUND_TIMEOUT));
    assign w_last_draw   = (r_draw_cnt == DRW_W'(DRAW_WAIT - 1));
    assign w_round_empty = (r_entry_count == '0);
    assign w_round_start = (r_state == ST_IDLE) && (w_state_next == ST_CLEAR);
    assign w_do_grant    = w_grant_en && w_grant_any;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req),
        .advance   (w_grant_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are only enabled in OPEN cycles where no exit condition holds.
    always_comb begin
        w_state_next  = r_state;
        w_grant_en    = 1'b0;
        w_result_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_OPEN;
            end
            ST_OPEN: begin
                if (w_exit) begin
                    w_state_next = ST_DRAW;
                end else begin
                    w_grant_en = 1'b1;
                end
            end
            ST_DRAW: begin
                if (w_round_empty || w_last_draw) begin
                    w_state_next  = ST_RESULT;
                    w_result_load = 1'b1;
                end
            end
            ST_RESULT: begin
                if (bus.result_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Every output is derived from the next state so it lines up with that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry_count  <= '0;
            r_timer        <= '0;
            r_draw_cnt     <= '0;
            r_ack          <= '0;
            r_lot_write    <= 1'b0;
            r_lot_luckybit <= 1'b0;
            r_lot_stop     <= 1'b0;
            r_lot_clear    <= 1'b0;
            r_busy         <= 1'b0;
            r_round_open   <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_empty <= 1'b0;
        end else begin
            r_ack          <= w_do_grant ? w_grant : '0;
            r_lot_write    <= w_do_grant;
            r_lot_luckybit <= w_do_grant && bus.req_bit[w_grant_idx];
            r_lot_clear    <= (w_state_next == ST_CLEAR);
            r_lot_stop     <= (w_state_next == ST_DRAW) && !w_round_empty;
            r_busy         <= (w_state_next != ST_IDLE);
            r_round_open   <= (w_state_next == ST_OPEN);
            r_result_valid <= (w_state_next == ST_RESULT);
            r_draw_cnt     <= (r_state == ST_DRAW) ? r_draw_cnt + 1'b1 : '0;

            if (r_state == ST_OPEN && !w_exit) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_do_grant) begin
                r_entry_count <= r_entry_count + 1'b1;
            end
            if (w_result_load) begin
                r_result_id    <= w_round_empty ? '0 : bus.lot_winner;
                r_result_empty <= w_round_empty;
            end
            if (w_round_start) begin
                r_entry_count  <= '0;
                r_timer        <= '0;
                r_result_id    <= '0;
                r_result_empty <= 1'b0;
            end
        end
    end

`ifdef LOTTERY_OWNER_TRACK_EN
    logic [PORT_W-1:0] r_owner [MAX_ENTRIES];
    logic [PORT_W-1:0] r_result_port;

    always_ff @(posedge clk) begin
        if (w_do_grant) begin
            r_owner[r_entry_count[ID_W-1:0]] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_port <= '0;
        end else if (w_round_start) begin
            r_result_port <= '0;
        end else if (w_result_load) begin
            r_result_port <= w_round_empty ? '0 : r_owner[bus.lot_winner];
        end
    end

    assign bus.result_port = r_result_port;
`else
    assign bus.result_port = '0;
`endif

    assign bus.ack          = r_ack;
    assign bus.lot_write    = r_lot_write;
    assign bus.lot_luckybit = r_lot_luckybit;
    assign bus.lot_stop     = r_lot_stop;
    assign bus.lot_clear    = r_lot_clear;
    assign bus.busy         = r_busy;
    assign bus.round_open   = r_round_open;
    assign bus.entry_count  = r_entry_count;
    assign bus.result_valid = r_result_valid;
    assign bus.result_id    = r_result_id;
    assign bus.result_empty = r_result_empty;
endmodule

`default_nettype wire

// File: tb/tb_lottery_round_ctrl.sv
// ============================================================================
// Module      : tb_lottery_round_ctrl
// Description : Scoreboard bench for lottery_round_ctrl with a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lottery_round_ctrl;
    import lottery_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int ROUND_TIMEOUT = 40;
    localparam int DRAW_WAIT     = 3;

    typedef struct { int idx; int lucky; int count; } grant_t;
    typedef struct { int id;  int port;  int empty; } result_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    lottery_round_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

    lottery_round_ctrl #(
        .NUM_REQ       (NUM_REQ),
        .ROUND_TIMEOUT (ROUND_TIMEOUT),
        .DRAW_WAIT     (DRAW_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    grant_t  grant_q  [$];
    result_t result_q [$];
    int      stop_q   [$];
    int      clear_q  [$];

    int m_ptr = 0;
    int m_count = 0;
    int m_owner [32];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after the slot following the last grant.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ack"},          int'(bus.ack), 0);
        chk({tag, "_lot_write"},    int'(bus.lot_write), 0);
        chk({tag, "_lot_luckybit"}, int'(bus.lot_luckybit), 0);
        chk({tag, "_lot_stop"},     int'(bus.lot_stop), 0);
        chk({tag, "_lot_clear"},    int'(bus.lot_clear), 0);
        chk({tag, "_busy"},         int'(bus.busy), 0);
        chk({tag, "_round_open"},   int'(bus.round_open), 0);
        chk({tag, "_entry_count"},  int'(bus.entry_count), 0);
        chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
        chk({tag, "_result_id"},    int'(bus.result_id), 0);
        chk({tag, "_result_port"},  int'(bus.result_port), 0);
        chk({tag, "_result_empty"}, int'(bus.result_empty), 0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        clear_q.push_back(1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        m_count = 0;
    endtask

    // Issue one OPEN cycle to the model; returns 1 when the round should close.
    task automatic open_cycle(input int k, input logic [NUM_REQ-1:0] r,
                              input logic [NUM_REQ-1:0] b, input logic full,
                              output bit closing);
        grant_t g;
        int     idx;
        bus.req      = r;
        bus.req_bit  = b;
        bus.lot_full = full;
        chk("round_open", int'(bus.round_open), 1);
        chk("busy_open",  int'(bus.busy), 1);
        closing = full || (m_count == 32) || (k >= ROUND_TIMEOUT);
        if (!closing) begin
            idx = rr_pick(r, m_ptr);
            if (idx >= 0) begin
                g.idx   = idx;
                g.lucky = int'(b[idx]);
                g.count = m_count + 1;
                grant_q.push_back(g);
                m_owner[m_count] = idx;
                m_count++;
                m_ptr = (idx + 1) % NUM_REQ;
            end
        end
    endtask

    // mode 0 random, 1 single requester, 2 all requesting, 3 fill to 32, 4 no requests
    task automatic run_round(input int mode);
        logic [NUM_REQ-1:0] r, b;
        logic               full;
        bit                 closing;
        int                 winner, junk, w;
        result_t            res;
        pulse_start();
        for (int k = 0; k < 200; k++) begin
            b    = NUM_REQ'($urandom);
            full = 1'b0;
            case (mode)
                1:       begin r = (k < 3) ? 4'b0001 : 4'b0000; b = 4'b0001; end
                2:       r = (k < 8) ? 4'b1111 : 4'b0000;
                3:       begin r = NUM_REQ'($urandom_range(15, 1)); full = (m_count == 32); end
                4:       r = '0;
                default: begin
                    r    = ($urandom % 3 == 0) ? '0 : NUM_REQ'($urandom);
                    full = (m_count > 0) && ($urandom % 50 == 0);
                    bus.start = ($urandom % 8 == 0);
                end
            endcase
            open_cycle(k, r, b, full, closing);
            if (closing) begin
                winner = (mode == 3) ? 7 : (m_count > 0 ? $urandom_range(m_count - 1, 0) : 0);
                junk   = winner ^ 5'h15;
                bus.lot_winner = ID_W'(junk);
                if (m_count > 0) begin
                    stop_q.push_back(DRAW_WAIT);
                    res.id    = winner;
                    res.empty = 0;
`ifdef LOTTERY_OWNER_TRACK_EN
                    res.port  = m_owner[winner];
`else
                    res.port  = 0;
`endif
                end else begin
                    res.id = 0; res.port = 0; res.empty = 1;
                end
                result_q.push_back(res);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.lot_full = 1'b0;
        // Only the value present in the last lot_stop cycle is the real winner.
        w = 0;
        while (!bus.result_valid && w < 40) begin
            bus.lot_winner = ID_W'((w == DRAW_WAIT - 1) ? winner : junk);
            @(negedge clk);
            w++;
        end
        chk("result_valid_arrives", int'(bus.result_valid), 1);
        chk("entry_count_final", int'(bus.entry_count), m_count);
        bus.req = '0;
        repeat ($urandom_range(3, 0)) begin
            bus.start = (mode == 0) && ($urandom % 2 == 0);
            @(negedge clk);
        end
        bus.start      = 1'b0;
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        chk("busy_after_ack", int'(bus.busy), 0);
        chk("valid_after_ack", int'(bus.result_valid), 0);
    endtask

    task automatic reset_mid_round();
        bit closing;
        pulse_start();
        for (int k = 0; k < 30 && m_count < 5; k++) begin
            open_cycle(k, NUM_REQ'($urandom_range(15, 1)), NUM_REQ'($urandom), 1'b0, closing);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1 check_outputs_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        grant_q.delete();
        m_ptr = 0;
        bus.req = '0;
        @(negedge clk);
        chk("idle_after_reset_busy", int'(bus.busy), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin : p_monitor
        grant_t  g;
        result_t cur;
        int      stop_run = 0;
        bit      prev_valid = 0;
        cur.id = 0; cur.port = 0; cur.empty = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stop_run   = 0;
                prev_valid = 0;
            end else begin
                if (bus.ack != '0 || bus.lot_write) begin
                    if (grant_q.size() == 0) begin
                        chk("unexpected_ack", int'(bus.ack), 0);
                    end else begin
                        g = grant_q.pop_front();
                        chk("ack_onehot",   int'(bus.ack), 1 << g.idx);
                        chk("lot_write",    int'(bus.lot_write), 1);
                        chk("lot_luckybit", int'(bus.lot_luckybit), g.lucky);
                        chk("entry_count",  int'(bus.entry_count), g.count);
                    end
                end
                if (bus.lot_stop) begin
                    stop_run++;
                end else if (stop_run > 0) begin
                    if (stop_q.size() == 0) chk("unexpected_lot_stop", stop_run, 0);
                    else                    chk("lot_stop_len", stop_run, stop_q.pop_front());
                    stop_run = 0;
                end
                if (bus.lot_clear) begin
                    if (clear_q.size() == 0) chk("unexpected_lot_clear", 1, 0);
                    else begin
                        void'(clear_q.pop_front());
                        chk("clear_entry_count", int'(bus.entry_count), 0);
                    end
                end
                if (bus.result_valid && !prev_valid) begin
                    if (result_q.size() == 0) chk("unexpected_result", 1, 0);
                    else cur = result_q.pop_front();
                end
                if (bus.result_valid) begin
                    chk("result_id",    int'(bus.result_id), cur.id);
                    chk("result_port",  int'(bus.result_port), cur.port);
                    chk("result_empty", int'(bus.result_empty), cur.empty);
                    chk("result_lot_stop_low", int'(bus.lot_stop), 0);
                end
                prev_valid = bus.result_valid;
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_driver
        bus.start      = 1'b0;
        bus.req        = '0;
        bus.req_bit    = '0;
        bus.lot_full   = 1'b0;
        bus.lot_winner = '0;
        bus.result_ack = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        chk("idle_ignores_req", int'(bus.ack), 0);
        bus.req = '0;

        run_round(1);
        reset_mid_round();
        run_round(2);
        run_round(3);
        run_round(4);
        for (int n = 0; n < 10; n++) run_round(0);

        repeat (3) @(negedge clk);
        chk("grant_q_drained",  grant_q.size(), 0);
        chk("result_q_drained", result_q.size(), 0);
        chk("stop_q_drained",   stop_q.size(), 0);
        chk("clear_q_drained",  clear_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
